// File: rtl/ssd_pkg.sv
// Shared seven-segment pattern table (active-low, bit0=a .. bit6=g) and decoder.
// The encoder and ssd_capture both use these constants, so one table governs both directions.
package ssd_pkg;

  localparam logic [6:0] SSD_0     = 7'h40;
  localparam logic [6:0] SSD_1     = 7'h79;
  localparam logic [6:0] SSD_2     = 7'h24;
  localparam logic [6:0] SSD_3     = 7'h30;
  localparam logic [6:0] SSD_4     = 7'h19;
  localparam logic [6:0] SSD_5     = 7'h12;
  localparam logic [6:0] SSD_6     = 7'h02;
  localparam logic [6:0] SSD_7     = 7'h78;
  localparam logic [6:0] SSD_8     = 7'h00;
  localparam logic [6:0] SSD_9     = 7'h10;
  localparam logic [6:0] SSD_A     = 7'h08;
  localparam logic [6:0] SSD_B     = 7'h03;
  localparam logic [6:0] SSD_C     = 7'h46;
  localparam logic [6:0] SSD_D     = 7'h21;
  localparam logic [6:0] SSD_E     = 7'h06;
  localparam logic [6:0] SSD_F     = 7'h0E;
  localparam logic [6:0] SSD_BLANK = 7'h7F;

  typedef enum logic {SETTLE, HOLD} cap_state_t;

  // Returns {err, blank, nibble}; blank and undecodable patterns both report nibble 0.
  function automatic logic [5:0] ssd_decode(input logic [6:0] seg_n);
    logic [5:0] r;
    r = 6'b10_0000;
    case (seg_n)
      SSD_0:     r = 6'h00;
      SSD_1:     r = 6'h01;
      SSD_2:     r = 6'h02;
      SSD_3:     r = 6'h03;
      SSD_4:     r = 6'h04;
      SSD_5:     r = 6'h05;
      SSD_6:     r = 6'h06;
      SSD_7:     r = 6'h07;
      SSD_8:     r = 6'h08;
      SSD_9:     r = 6'h09;
      SSD_A:     r = 6'h0A;
      SSD_B:     r = 6'h0B;
      SSD_C:     r = 6'h0C;
      SSD_D:     r = 6'h0D;
      SSD_E:     r = 6'h0E;
      SSD_F:     r = 6'h0F;
      SSD_BLANK: r = 6'b01_0000;
      default:   r = 6'b10_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ssd_sync2.sv
// Parameterized-width two-flop synchronizer; both stages reset to RESET_VAL.
module ssd_sync2 #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// Watches a multiplexed 4-digit seven-segment bus, captures each settled digit
// and delivers the reassembled 16-bit value once all four digits have been seen.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        seg_err,
  output logic [3:0]  blank_mask,
  output logic        stale
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      STAB_MAX = 8'(STABLE_CYC - 1);
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYC);

  logic [1:0]    rst_ff;
  logic          rst_sync_n;
  logic [3:0]    an_s, an_prev;
  logic [6:0]    seg_s, seg_prev;
  logic          same;
  logic          sel_valid;
  logic [1:0]    sel;
  logic [5:0]    dec;
  cap_state_t    state, state_next;
  logic [7:0]    stab_cnt, stab_next;
  logic          capture;
  logic [3:0]    seen;
  logic          complete;
  logic [15:0]   slot_val;
  logic [3:0]    slot_blank, slot_err;
  logic [TW-1:0] to_cnt;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ff <= 2'b00;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_sync_n = rst_ff[1];

  ssd_sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync_an (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .d    (an_n),
    .q    (an_s)
  );

  ssd_sync2 #(.WIDTH(7), .RESET_VAL(7'h7F)) u_sync_seg (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .d    (seg_n),
    .q    (seg_s)
  );

  assign same     = ({an_s, seg_s} == {an_prev, seg_prev});
  assign dec      = ssd_decode(seg_s);
  assign complete = (seen == 4'hF);
  assign stale    = (to_cnt == TO_MAX);

  // Only a single low anode identifies a digit; anything else is never captured.
  always_comb begin
    sel_valid = 1'b1;
    sel       = 2'd0;
    case (an_s)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= SETTLE;
      stab_cnt <= 8'd0;
      an_prev  <= 4'hF;
      seg_prev <= 7'h7F;
    end else begin
      state    <= state_next;
      stab_cnt <= stab_next;
      an_prev  <= an_s;
      seg_prev <= seg_s;
    end
  end

  always_comb begin
    state_next = state;
    stab_next  = stab_cnt;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (!same) begin
          stab_next = 8'd0;
        end else if (stab_cnt < STAB_MAX) begin
          stab_next = stab_cnt + 8'd1;
        end else if (sel_valid) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!same) begin
          state_next = SETTLE;
          stab_next  = 8'd0;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // A capture landing on the completion cycle belongs to the next frame;
  // the delivered frame reads the slot contents from before that edge.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      seen        <= 4'h0;
      slot_val    <= 16'h0;
      slot_blank  <= 4'h0;
      slot_err    <= 4'h0;
      value       <= 16'h0;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      blank_mask  <= 4'h0;
      to_cnt      <= '0;
    end else begin
      seen <= (complete ? 4'h0 : seen) | (capture ? (4'b0001 << sel) : 4'h0);
      if (capture) begin
        slot_val[{sel, 2'b00} +: 4] <= dec[3:0];
        slot_blank[sel]             <= dec[4];
        slot_err[sel]               <= dec[5];
      end
      if (complete) begin
        value       <= slot_val;
        blank_mask  <= slot_blank;
        seg_err     <= |slot_err;
        value_valid <= 1'b1;
        to_cnt      <= '0;
      end else begin
        value_valid <= 1'b0;
        if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: full scans, blank/error digits, short dwells,
// timeout, glitch rejection and mid-frame reset.
module tb_ssd_capture;

  localparam int STABLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] value;
  logic        value_valid;
  logic        seg_err;
  logic [3:0]  blank_mask;
  logic        stale;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          base;
  logic [15:0] cap_value = 16'h0;
  logic        cap_err = 1'b0;
  logic [3:0]  cap_blank = 4'h0;

  ssd_capture #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .value      (value),
    .value_valid(value_valid),
    .seg_err    (seg_err),
    .blank_mask (blank_mask),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  // Record every delivered frame, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (value_valid) begin
      valid_cnt++;
      cap_value = value;
      cap_err   = seg_err;
      cap_blank = blank_mask;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int digit, input logic [6:0] pattern, input int dwell);
    an_n  = ~(4'b0001 << digit);
    seg_n = pattern;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                      input logic [6:0] p0, input int dwell);
    applyStimulus(3, p3, dwell);
    applyStimulus(2, p2, dwell);
    applyStimulus(1, p1, dwell);
    applyStimulus(0, p0, dwell);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    checkOutput("rst_value", 32'(value), 32'h0);
    checkOutput("rst_valid", 32'(value_valid), 32'h0);
    checkOutput("rst_err", 32'(seg_err), 32'h0);
    checkOutput("rst_blank", 32'(blank_mask), 32'h0);
    checkOutput("rst_stale", 32'(stale), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Plain scan 4,3,2,1
    base = valid_cnt;
    scan(7'h19, 7'h30, 7'h24, 7'h79, 20);
    idle(5);
    checkOutput("scan_count", 32'(valid_cnt - base), 32'd1);
    checkOutput("scan_value", 32'(cap_value), 32'h4321);
    checkOutput("scan_err", 32'(cap_err), 32'h0);
    checkOutput("scan_blank", 32'(cap_blank), 32'h0);
    checkOutput("scan_value_held", 32'(value), 32'h4321);

    // Digit 2 blank
    base = valid_cnt;
    scan(7'h19, 7'h7F, 7'h24, 7'h79, 20);
    idle(5);
    checkOutput("blank_count", 32'(valid_cnt - base), 32'd1);
    checkOutput("blank_value", 32'(cap_value), 32'h4021);
    checkOutput("blank_mask", 32'(cap_blank), 32'h4);
    checkOutput("blank_err", 32'(cap_err), 32'h0);

    // Digit 0 undecodable, then a clean frame
    base = valid_cnt;
    scan(7'h19, 7'h30, 7'h24, 7'h55, 20);
    idle(5);
    checkOutput("err_count", 32'(valid_cnt - base), 32'd1);
    checkOutput("err_value", 32'(cap_value), 32'h4320);
    checkOutput("err_flag", 32'(cap_err), 32'h1);
    checkOutput("err_blank", 32'(cap_blank), 32'h0);
    scan(7'h19, 7'h30, 7'h24, 7'h79, 20);
    idle(5);
    checkOutput("clean_count", 32'(valid_cnt - base), 32'd2);
    checkOutput("clean_err", 32'(cap_err), 32'h0);
    checkOutput("clean_value", 32'(cap_value), 32'h4321);
    checkOutput("fresh_stale", 32'(stale), 32'h0);

    // Short dwells and multi-anode samples never capture; timeout follows
    base = valid_cnt;
    scan(7'h40, 7'h40, 7'h40, 7'h40, 5);
    an_n  = 4'b0011;
    seg_n = 7'h24;
    repeat (40) @(negedge clk);
    checkOutput("short_count", 32'(valid_cnt - base), 32'd0);
    idle(30);
    checkOutput("timeout_count", 32'(valid_cnt - base), 32'd0);
    checkOutput("timeout_stale", 32'(stale), 32'h1);
    checkOutput("timeout_value", 32'(value), 32'h4321);

    // Brief glitch to 8 within digit 1's dwell
    base = valid_cnt;
    applyStimulus(3, 7'h19, 20);
    applyStimulus(2, 7'h30, 20);
    applyStimulus(1, 7'h79, 14);
    applyStimulus(1, 7'h00, 3);
    applyStimulus(1, 7'h79, 20);
    applyStimulus(0, 7'h24, 20);
    idle(5);
    checkOutput("glitch_count", 32'(valid_cnt - base), 32'd1);
    checkOutput("glitch_value", 32'(cap_value), 32'h4312);
    checkOutput("glitch_stale", 32'(stale), 32'h0);

    // Reset after three captured digits discards them
    applyStimulus(3, 7'h19, 20);
    applyStimulus(2, 7'h30, 20);
    applyStimulus(1, 7'h24, 20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_value", 32'(value), 32'h0);
    checkOutput("midrst_stale", 32'(stale), 32'h0);
    checkOutput("midrst_err", 32'(seg_err), 32'h0);
    rst_n = 1'b1;
    base = valid_cnt;
    scan(7'h0E, 7'h06, 7'h21, 7'h46, 20);
    idle(5);
    checkOutput("post_rst_count", 32'(valid_cnt - base), 32'd1);
    checkOutput("post_rst_value", 32'(cap_value), 32'hFEDC);
    checkOutput("post_rst_blank", 32'(cap_blank), 32'h0);
    checkOutput("post_rst_stale", 32'(stale), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Monitors a time-multiplexed 4-digit seven-segment bus (active-low anodes, active-low segments) and waits for each digit's pattern to settle.
- Decodes each settled pattern back to a nibble and assembles a 16-bit value once all four digits have been seen.
- Used for display loop-back self-test and for bench observation of the pipeline's debug display.

Parameters:
- STABLE_CYC, 8: consecutive identical samples required before a digit is captured (legal range 2..255).
- TIMEOUT_CYC, 65535: cycles without a completed frame before stale asserts (legal range >= 16).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- an_n  input  4  digit anodes, active-low; bit i selects digit i (bit 3 = most significant nibble)
- seg_n  input  7  segments, active-low; bit0=a … bit6=g
- value  output  16  last completed frame, digit i in value[4i+3:4i]
- value_valid  output  1  one-cycle pulse when value updates
- seg_err  output  1  frame just delivered contained at least one undecodable, non-blank pattern; valid with value_valid
- blank_mask  output  4  digits captured as all-off (seg_n=7'h7F) in the delivered frame
- stale  output  1  level; no frame completed in last TIMEOUT_CYC cycles

Behaviour:
- Reset (async assert, sync deassert via 2-FF reset synchronizer): value=0, value_valid=0, seg_err=0, blank_mask=0, stale=0; sync flops=all-ones; seen mask=0; counters=0; FSM=SETTLE.
- Input sync: an_n and seg_n each pass through 2-FF synchronizers. All decisions use the synced sample s = {an_s, seg_s}.
- Decode table (seg_n -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - 7F -> blank; nibble 0, blank bit set.
  - Any other pattern -> error; nibble 0, error bit set.
- Digit select is valid only when exactly one an_s bit is 0. Zero or multiple low anodes form an unselected sample and are never captured.
- FSM SETTLE:
  - stab_cnt increments while s equals the previous sample; any change resets it to 0.
  - When stab_cnt reaches STABLE_CYC-1 and the select is valid, capture the slot next cycle and go to HOLD.
  - When stab_cnt reaches STABLE_CYC-1 with an unselected sample, stay in SETTLE and saturate the count.
- Capture writes the slot's nibble, blank bit and error bit, and sets seen[i].
  - Recapturing an already-seen slot before the frame completes overwrites it; last capture wins.
- FSM HOLD: no recapture of the same dwell. Any change in s -> SETTLE with stab_cnt=0.
- Frame completion: in the cycle after seen becomes 4'hF:
  - value, blank_mask and seg_err load from the slots; value_valid=1 for exactly that cycle.
  - seen clears and the timeout counter clears.
- Latency: from a change on the pins held steady, capture occurs at 2 (sync) + STABLE_CYC + 1 cycles. value_valid follows the capture that completes the frame by 1 cycle.
- Capture on the same cycle as frame completion: the new capture is counted toward the next frame. The completing frame uses the slot contents from before that cycle.
- Timeout counter: increments each cycle and saturates at TIMEOUT_CYC.
  - stale=1 while saturated; clears in the value_valid cycle.
  - value keeps its last contents while stale.
- Reset mid-dwell or mid-frame: all partial captures are discarded and the outputs return to their reset values.
- Glitch shorter than STABLE_CYC inside a dwell: forces HOLD->SETTLE, but the same pattern recaptures harmlessly after settling.

Decomposition:
- Package ssd_pkg holds:
  - the 16-entry active-low pattern constants (SSD_0..SSD_F) and SSD_BLANK=7'h7F;
  - function ssd_decode(seg_n) returning {err, blank, nibble};
  - FSM state enum {SETTLE, HOLD}.
- The encoder and this block share the pattern constants, so one table governs both directions.
- One sub-module: ssd_sync2, a parameterized-width 2-FF synchronizer instanced for an_n and seg_n.

Test Plan:
- Scan digits 3..0 with patterns 19,30,24,79, 20-cycle dwell each, STABLE_CYC=8 -> single value_valid, value=16'h4321, seg_err=0, blank_mask=0.
- Same scan with digit 2 driving 7'h7F -> value=16'h4021, blank_mask=4'b0100, seg_err=0.
- Digit 0 driving 7'h55 -> value[3:0]=0, seg_err=1 in the valid cycle. The next clean frame returns seg_err=0.
- Each dwell 5 cycles, or an_n=4'b0011 held 40 cycles -> no value_valid, no capture. After TIMEOUT_CYC=64, stale=1.
- 3-cycle glitch of seg_n to 7'h00 inside digit 1's dwell, then return to 7'h79 -> value digit 1 = 1, not 8.
- rst_n pulsed low after 3 of 4 digits are captured, then a full scan of 0E,06,21,46 -> exactly one value_valid, value=16'hFEDC, no stale.
